// File: rtl/j11intc.sv
// j11intc: vectored interrupt controller driving the four J11 bus-request levels.
// Ports: clk, rstn (async active-low); irq[NCHAN] raw requests; ackreq/acklvl acknowledge
// request, ackdone/ackvec/ackmiss acknowledge result; j11irq[4] bus requests;
// regreq/regwdata/regack mask-register write. Define J11INTC_MASK_EN for the mask register.
module j11intc #(
  parameter int NCHAN = 8,
  parameter logic [NCHAN*16-1:0] VEC = '0,
  parameter logic [NCHAN*2-1:0] LVL = '0,
  parameter logic [NCHAN-1:0] EDGE = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NCHAN-1:0]  irq,
  input  logic              ackreq,
  input  logic [3:0]        acklvl,
  output logic              ackdone,
  output logic [15:0]       ackvec,
  output logic              ackmiss,
  output logic [3:0]        j11irq,
  input  logic              regreq,
  input  logic [31:0]       regwdata,
  output logic              regack
);
  logic [NCHAN-1:0] s1_q, s2_q, s3_q, pend_q, pend_d, mask, elig, set, clr, win_oh;
  logic [3:0] j11irq_q, j11irq_d;
  logic [15:0] ackvec_q, ackvec_d, win_vec;
  logic ackdone_q, ackdone_d, ackmiss_q, ackmiss_d, regack_q, regack_d, hit;
  logic [1:0] lvl;
  logic unused_wdata;
  assign unused_wdata = ^regwdata;
`ifdef J11INTC_MASK_EN
  logic [NCHAN-1:0] mask_q, mask_d;
  assign mask_d = regreq ? regwdata[NCHAN-1:0] : mask_q;
  assign mask = mask_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) mask_q <= '0;
    else mask_q <= mask_d;
`else
  assign mask = '0;
`endif
  always_comb begin
    elig = pend_q & ~mask;
    lvl = acklvl[3] ? 2'd3 : acklvl[2] ? 2'd2 : acklvl[1] ? 2'd1 : 2'd0;
    hit = 1'b0;
    win_oh = '0;
    win_vec = '0;
    // descending scan so the lowest-index eligible channel is the last one kept
    for (int i = NCHAN - 1; i >= 0; i--)
      if (elig[i] && LVL[2*i +: 2] == lvl) begin
        hit = 1'b1;
        win_oh = '0;
        win_oh[i] = 1'b1;
        win_vec = VEC[16*i +: 16];
      end
    hit = hit & |acklvl;
    j11irq_d = '0;
    for (int i = 0; i < NCHAN; i++)
      j11irq_d[LVL[2*i +: 2]] = j11irq_d[LVL[2*i +: 2]] | elig[i];
    clr = (ackreq && hit) ? win_oh : '0;
    set = s2_q & (~EDGE | ~s3_q);
    // edge channels keep a coincident new event; level channels let the clear win
    pend_d = (pend_q & ~clr) | (set & (EDGE | ~clr));
    ackdone_d = ackreq;
    ackmiss_d = ackreq & ~hit;
    ackvec_d = (ackreq && hit) ? win_vec : 16'o0;
    regack_d = regreq;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      pend_q <= '0;
      j11irq_q <= '0;
      ackdone_q <= 1'b0;
      ackmiss_q <= 1'b0;
      ackvec_q <= 16'o0;
      regack_q <= 1'b0;
    end else begin
      s1_q <= irq;
      s2_q <= s1_q;
      s3_q <= s2_q;
      pend_q <= pend_d;
      j11irq_q <= j11irq_d;
      ackdone_q <= ackdone_d;
      ackmiss_q <= ackmiss_d;
      ackvec_q <= ackvec_d;
      regack_q <= regack_d;
    end
  assign j11irq = j11irq_q;
  assign ackdone = ackdone_q;
  assign ackmiss = ackmiss_q;
  assign ackvec = ackvec_q;
  assign regack = regack_q;
endmodule

// File: tb/tb_j11intc.sv
// tb_j11intc: directed and random checks of j11intc against a behavioural model.
module tb_j11intc;
  localparam int N = 6;
  localparam logic [N*16-1:0] P_VEC = {16'o340, 16'o300, 16'o160, 16'o64, 16'o60, 16'o100};
  localparam logic [N*2-1:0]  P_LVL = {2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [N-1:0]    P_EDGE = 6'b100000;
  logic clk = 1'b0, rstn;
  logic [N-1:0] irq;
  logic ackreq, regreq, ackdone, ackmiss, regack;
  logic [3:0] acklvl, j11irq;
  logic [15:0] ackvec;
  logic [31:0] regwdata;
  int n_vec = 0, n_err = 0;
  int lv [N] = '{0, 0, 0, 0, 1, 3};
  bit edg [N] = '{0, 0, 0, 0, 0, 1};
  logic [15:0] vv [N] = '{16'o100, 16'o60, 16'o64, 16'o160, 16'o300, 16'o340};
  bit pend_m [N];
  bit mask_m [N];
  logic [N-1:0] irqh [$];
  logic [3:0] e_j11;
  logic e_done, e_miss, e_regack;
  logic [15:0] e_vec;

  j11intc #(.NCHAN(N), .VEC(P_VEC), .LVL(P_LVL), .EDGE(P_EDGE)) dut (
    .clk(clk), .rstn(rstn), .irq(irq), .ackreq(ackreq), .acklvl(acklvl),
    .ackdone(ackdone), .ackvec(ackvec), .ackmiss(ackmiss), .j11irq(j11irq),
    .regreq(regreq), .regwdata(regwdata), .regack(regack));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      pend_m[i] = 0;
      mask_m[i] = 0;
    end
    irqh = '{'0, '0, '0};
    e_j11 = '0; e_done = 0; e_miss = 0; e_regack = 0; e_vec = '0;
  endtask

  // irqh[0..2] hold irq as sampled at the previous three edges;
  // the synchronised value seen at an edge is irq from two edges earlier.
  task automatic model_edge();
    bit el [N];
    int sel, w;
    bit s2, s3, st;
    e_j11 = '0;
    for (int i = 0; i < N; i++) begin
      el[i] = pend_m[i] && !mask_m[i];
      if (el[i]) e_j11[lv[i]] = 1'b1;
    end
    sel = -1;
    for (int n = 0; n < 4; n++) if (acklvl[n]) sel = n;
    w = -1;
    if (ackreq && sel >= 0)
      for (int i = N - 1; i >= 0; i--) if (el[i] && lv[i] == sel) w = i;
    e_done = ackreq;
    e_miss = ackreq && w < 0;
    e_vec = (ackreq && w >= 0) ? vv[w] : 16'o0;
    e_regack = regreq;
    for (int i = 0; i < N; i++) begin
      s2 = irqh[1][i];
      s3 = irqh[2][i];
      st = edg[i] ? (s2 && !s3) : s2;
      if (i == w) pend_m[i] = edg[i] ? st : 1'b0;
      else pend_m[i] = pend_m[i] | st;
    end
`ifdef J11INTC_MASK_EN
    if (regreq) for (int i = 0; i < N; i++) mask_m[i] = regwdata[i];
`endif
    irqh.push_front(irq);
    void'(irqh.pop_back());
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("j11irq", j11irq, e_j11);
    chk("ackdone", ackdone, e_done);
    chk("ackvec", ackvec, e_vec);
    chk("ackmiss", ackmiss, e_miss);
    chk("regack", regack, e_regack);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_j11irq"}, j11irq, 4'b0);
    chk({tag, "_ackdone"}, ackdone, 1'b0);
    chk({tag, "_ackvec"}, ackvec, 16'o0);
    chk({tag, "_ackmiss"}, ackmiss, 1'b0);
    chk({tag, "_regack"}, regack, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; irq = '0; ackreq = 0; acklvl = '0; regreq = 0; regwdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    // single level channel: request reaches j11irq three edges after first sample
    irq = 6'b000010;
    cyc(); cyc(); cyc();
    chk("e2_idle", j11irq, 4'b0000);
    cyc();
    chk("e3_j11irq", j11irq, 4'b0001);
    ackreq = 1; acklvl = 4'b0001;
    cyc();
    chk("ack1_vec", ackvec, 16'o60);
    chk("ack1_miss", ackmiss, 1'b0);
    chk("ack1_done", ackdone, 1'b1);
    ackreq = 0; irq = '0;
    cyc(); cyc(); cyc();
    for (int k = 0; k < 4; k++) begin
      ackreq = 1; acklvl = 4'b0001;
      cyc();
    end
    ackreq = 0;
    // two channels on level 0, back-to-back acknowledges
    irq = 6'b000101;
    cyc(); cyc(); cyc();
    irq = '0;
    cyc(); cyc(); cyc();
    ackreq = 1; acklvl = 4'b0001;
    cyc();
    chk("b2b_first", ackvec, 16'o100);
    cyc();
    chk("b2b_second", ackvec, 16'o64);
    cyc();
    chk("b2b_miss", ackmiss, 1'b1);
    chk("b2b_missvec", ackvec, 16'o0);
    chk("b2b_j11irq0", j11irq[0], 1'b0);
    ackreq = 0;
    // edge channel: new rising edge coincides with its acknowledge clear
    irq = 6'b100000;
    cyc();
    irq = '0;
    cyc(); cyc(); cyc(); cyc();
    irq = 6'b100000;
    cyc();
    irq = '0;
    cyc();
    ackreq = 1; acklvl = 4'b1000;
    cyc();
    chk("edge_ack1", ackvec, 16'o340);
    cyc();
    chk("edge_ack2", ackvec, 16'o340);
    cyc();
    chk("edge_ack3_miss", ackmiss, 1'b1);
    ackreq = 0;
    // levels 1 and 3 together
    irq = 6'b110000;
    cyc(); cyc(); cyc(); cyc();
    chk("lv13_j11irq", j11irq, 4'b1010);
    ackreq = 1; acklvl = 4'b1010;
    cyc();
    chk("lv13_vec", ackvec, 16'o340);
    acklvl = 4'b0000;
    cyc();
    chk("lvl0_miss", ackmiss, 1'b1);
    chk("lvl0_vec", ackvec, 16'o0);
    acklvl = 4'b0010;
    cyc();
    chk("lv1_vec", ackvec, 16'o300);
    ackreq = 0; irq = '0;
    cyc(); cyc(); cyc();
    ackreq = 1; acklvl = 4'b0010;
    cyc();
    ackreq = 0;
`ifdef J11INTC_MASK_EN
    regreq = 1; regwdata = 32'h1;
    cyc();
    regreq = 0; irq = 6'b000001;
    cyc(); cyc(); cyc(); cyc();
    chk("masked_j11irq", j11irq, 4'b0000);
    ackreq = 1; acklvl = 4'b0001;
    cyc();
    chk("masked_miss", ackmiss, 1'b1);
    ackreq = 0; regreq = 1; regwdata = 32'h0;
    cyc();
    regreq = 0;
    cyc();
    chk("unmask_j11irq", j11irq, 4'b0001);
`else
    regreq = 1; regwdata = 32'hffff_ffff;
    cyc();
    chk("nomask_regack", regack, 1'b1);
    regreq = 0; irq = 6'b000001;
    cyc(); cyc(); cyc(); cyc();
    chk("nomask_j11irq", j11irq, 4'b0001);
`endif
    // asynchronous reset with pending state and an acknowledge in flight
    ackreq = 1; acklvl = 4'b0010; regreq = 1; regwdata = 32'h0;
    cyc();
    chk("pre_rst_done", ackdone, 1'b1);
    chk("pre_rst_j11", j11irq, 4'b0001);
    acklvl = 4'b0001;
    #2 rstn = 1'b0;
    #1 chk_zero("async_rst");
    ackreq = 0; regreq = 0;
    @(posedge clk);
    #1 chk("rst_hold_done", ackdone, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    cyc(); cyc(); cyc();
    // random traffic
    irq = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) irq[i] = ~irq[i];
      ackreq = ($urandom_range(2) == 0);
      acklvl = 4'($urandom);
      regreq = ($urandom_range(4) == 0);
      regwdata = $urandom & $urandom;
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
